// File: rtl/dmem_responder.sv
// ============================================================================
// Module  : dmem_responder
// Purpose : Memory side of the core's data load/store interface. Accepts one
//           request at a time over valid/ready, holds DEPTH_WORDS x 32-bit
//           storage and answers after a fixed LATENCY.
// Config  : DMEM_ALIGN_CHECK_EN - when defined, addresses with
//           req_addr[1:0] != 0 are rejected with resp_err=1.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   rd_hold;
  logic          err_hold;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          misaligned;
  logic          req_err;
  logic          accept;
  logic [31:0]   load_data;

  // Address decode and the error/accept qualifiers for the request on the bus
  always_comb begin
    off      = req_addr - BASE_ADDR;
    idx      = off[AW+1:2];
    in_range = (off < SPAN);
`ifdef DMEM_ALIGN_CHECK_EN
    misaligned = (req_addr[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
    req_err   = !in_range || misaligned;
    // Gate with reset so a request sampled while reset is held never commits
    accept    = req_valid && req_ready && !reset;
    load_data = (req_we || req_err) ? 32'h0 : mem[idx];
  end

  // Storage: stores commit on the accept edge, lane by lane; never reset
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) begin
          mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake/response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_hold    <= 32'h0;
      err_hold   <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rd_hold   <= load_data;
            err_hold  <= req_err;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= load_data;
              resp_err   <= req_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= rd_hold;
            resp_err   <= err_hold;
          end
        end
        RESP: begin
          // Response held stable until the requester takes it
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module  : tb_dmem_responder
// Purpose : Directed, table-driven bench for dmem_responder
//           (DEPTH_WORDS=1024, LATENCY=2, BASE_ADDR=0). Honours
//           DMEM_ALIGN_CHECK_EN for the misaligned-address expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int LATENCY = 2;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic        ERR_MIS  = 1'b1;
  localparam logic [31:0] EXP_100  = 32'hDEAD_AAEF;
  localparam logic [31:0] EXP_MISL = 32'h0000_0000;
`else
  localparam logic        ERR_MIS  = 1'b0;
  localparam logic [31:0] EXP_100  = 32'h0000_0077;
  localparam logic [31:0] EXP_MISL = 32'h0000_0077;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY    (LATENCY),
    .BASE_ADDR  (32'h0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request for one edge; caller stands #1 after an edge in IDLE
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for resp_valid; returns edges counted from the accept edge
  task automatic wait_resp(output int edges);
    edges = 1;
    while (!resp_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // Full transaction: accept, latency, response contents, release
  task automatic txn(input vec_t v, input string tag);
    int edges;
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    issue(v.we, v.addr, v.wdata, v.be);
    wait_resp(edges);
    check({tag, "_latency"}, 32'(edges), 32'(LATENCY));
    check({tag, "_rdata"}, resp_rdata, v.rdata);
    check({tag, "_err"}, 32'(resp_err), 32'(v.err));
    check({tag, "_busy"}, {busy, req_ready}, 32'b10);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({tag, "_release"}, {resp_valid, req_ready, busy, resp_err}, 32'b0100);
    check({tag, "_rdata_clr"}, resp_rdata, 32'h0);
  endtask

  initial begin
    int edges;
    logic [31:0] held;

    vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0100, 32'h0000_AA00, 4'h2, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_1000, 32'h0000_1234, 4'hF, 32'h0, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 32'h0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h1122_3344, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h1122_3344, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 32'hA5A5_A5A5, 1'b0};
    vecs[12] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 32'h0, 1'b1};
    vecs[13] = '{1'b1, 32'h0000_0102, 32'h0000_0077, 4'hF, 32'h0, ERR_MIS};
    vecs[14] = '{1'b0, 32'h0000_0100, 32'h0,         4'hF, EXP_100, 1'b0};
    vecs[15] = '{1'b1, 32'h0000_0000, 32'h00CC_0000, 4'h4, 32'h0, 1'b0};
    vecs[16] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h11CC_3344, 1'b0};
    vecs[17] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};
    vecs[18] = '{1'b0, 32'h0000_0103, 32'h0,         4'hF, EXP_MISL, ERR_MIS};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_be     = 4'h0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {req_ready, resp_valid, busy, resp_err}, 32'b1000);
    check("reset_rdata", resp_rdata, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Response held with resp_ready low; a competing request must be ignored
    issue(1'b0, 32'h0000_0100, 32'h0, 4'hF);
    wait_resp(edges);
    check("hold_latency", 32'(edges), 32'(LATENCY));
    held      = resp_rdata;
    check("hold_first", held, EXP_100);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0100;
    req_wdata = 32'h0BAD_F00D;
    req_be    = 4'hF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_c%0d_flags", c), {resp_valid, req_ready, busy}, 32'b101);
      check($sformatf("hold_c%0d_rdata", c), resp_rdata, EXP_100);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("hold_release", {resp_valid, req_ready}, 32'b01);
    txn('{1'b0, 32'h0000_0100, 32'h0, 4'hF, EXP_100, 1'b0}, "hold_reload");

    // Reset while waiting: response dropped, store stays committed
    issue(1'b1, 32'h0000_0200, 32'h0000_0055, 4'hF);
    check("rst_wait_busy", {busy, resp_valid}, 32'b10);
    reset = 1'b1;
    #2;
    check("rst_wait_async", {resp_valid, req_ready, busy}, 32'b010);
    @(posedge clk);
    #1;
    check("rst_wait_next", {resp_valid, req_ready, busy}, 32'b010);
    reset = 1'b0;
    @(posedge clk);
    #1;
    txn('{1'b0, 32'h0000_0200, 32'h0, 4'hF, 32'h0000_0055, 1'b0}, "rst_reload");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so a stuck DUT still produces a summary
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: got no completion expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
